// File: rtl/muldiv_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : muldiv_pkg
// Purpose  : Shared definitions for the iterative multiply/divide unit:
//            MIPS funct codes, FSM state encoding and operation kind.
// Config   : MULDIV_DIV_EN (see muldiv_unit) -- no effect on this package.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
package muldiv_pkg;

   // MIPS R-type funct codes serviced by the unit
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_DIVU  = 6'b011011;
   localparam logic [5:0] FN_MTHI  = 6'b010001;
   localparam logic [5:0] FN_MTLO  = 6'b010011;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MFLO  = 6'b010010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_e;

   typedef enum logic {
      OP_MUL = 1'b0,
      OP_DIV = 1'b1
   } op_e;

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_core.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : muldiv_core
// Purpose  : One combinational iteration of the unsigned multiply/divide
//            datapath operating on a 2*WIDTH-bit accumulator.
//              multiply : radix-2 shift-add, acc = {partial product, multiplier}
//              divide   : restoring shift-subtract, acc = {remainder, quotient}
// Ports    : op_i     1          operation kind (OP_MUL / OP_DIV)
//            acc_i    2*WIDTH    accumulator before the step
//            opnd_i   WIDTH      multiplicand or divisor
//            acc_o    2*WIDTH    accumulator after the step
// Config   : MULDIV_DIV_EN undefined removes the divide step entirely.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module muldiv_core
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               op_i,
   input  logic [2*WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0]   opnd_i,
   output logic [2*WIDTH-1:0] acc_o
);

   // Multiply: add the multiplicand into the upper half when the current
   // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
   // The carry out of the add becomes the new MSB.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_acc;

   always_comb begin
      mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
      mul_acc = {mul_sum, acc_i[WIDTH-1:1]};
   end

`ifdef MULDIV_DIV_EN
   // Divide: shift {rem, dividend} left by one; the shifted remainder needs
   // WIDTH+1 bits. A clear borrow means the trial subtraction is kept and a
   // quotient 1 is shifted in. A zero divisor always "succeeds", which leaves
   // the dividend in the remainder and all ones in the quotient.
   logic [WIDTH:0]     div_part;
   logic [WIDTH:0]     div_trial;
   logic [2*WIDTH-1:0] div_acc;

   always_comb begin
      div_part  = acc_i[2*WIDTH-1:WIDTH-1];
      div_trial = div_part - {1'b0, opnd_i};
      if (!div_trial[WIDTH]) begin
         div_acc = {div_trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else begin
         div_acc = {div_part[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
   end

   assign acc_o = (op_i == OP_DIV) ? div_acc : mul_acc;
`else
   logic unused_op;
   assign unused_op = op_i;
   assign acc_o     = mul_acc;
`endif

endmodule : muldiv_core
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : muldiv_unit
// Purpose  : Iterative MULT/MULTU/DIV/DIVU engine with architectural HI/LO
//            registers, plus MTHI/MTLO writes. IDLE -> RUN (WIDTH cycles)
//            -> FIX (sign fix, HI/LO write, done pulse) -> IDLE.
// Ports    : clk     1      clock, rising edge
//            reset   1      synchronous active-high reset (clears HI/LO too)
//            start   1      request; qualifies Funct, A, B
//            Funct   6      MIPS funct code
//            A, B    WIDTH  rs / rt operands
//            cancel  1      pipeline flush, aborts an operation in flight
//            busy    1      operation in progress (RUN or FIX)
//            done    1      pulse in the cycle whose edge writes HI/LO
//            Hi, Lo  WIDTH  HI / LO registers
// Config   : MULDIV_DIV_EN -- when defined DIV/DIVU are executed; when
//            undefined they are no-ops and the divider is not built.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [5:0]       Funct,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int                CNT_W    = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

   state_e               state_q, state_d;
   op_e                  op_q, op_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 neg_res_q, neg_res_d;   // negate product / quotient
   logic                 neg_rem_q, neg_rem_d;   // remainder takes sign(A)
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;

   logic [2*WIDTH-1:0]   step_acc;
   logic                 is_mul, is_div, is_signed, b_zero;
   logic [WIDTH-1:0]     abs_a, abs_b;

   muldiv_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .op_i   (op_q),
      .acc_i  (acc_q),
      .opnd_i (opnd_q),
      .acc_o  (step_acc)
   );

   // Request decode and operand magnitudes
   always_comb begin
      is_mul    = (Funct == FN_MULT) || (Funct == FN_MULTU);
`ifdef MULDIV_DIV_EN
      is_div    = (Funct == FN_DIV) || (Funct == FN_DIVU);
`else
      is_div    = 1'b0;
`endif
      is_signed = (Funct == FN_MULT) || (Funct == FN_DIV);
      b_zero    = (B == '0);
      abs_a     = (is_signed && A[WIDTH-1]) ? -A : A;
      abs_b     = (is_signed && B[WIDTH-1]) ? -B : B;
   end

   // Next-state / output logic
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      cnt_d     = cnt_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start && !cancel) begin
               if (Funct == FN_MTHI) begin
                  hi_d = A;
               end else if (Funct == FN_MTLO) begin
                  lo_d = A;
               end else if (is_mul || is_div) begin
                  op_d      = is_div ? OP_DIV : OP_MUL;
                  opnd_d    = is_div ? abs_b : abs_a;
                  acc_d     = {{WIDTH{1'b0}}, (is_div ? abs_a : abs_b)};
                  cnt_d     = '0;
                  // Divide by zero leaves the quotient raw (all ones). The
                  // remainder fix still applies: it turns |A| back into A.
                  neg_res_d = is_signed && (A[WIDTH-1] ^ B[WIDTH-1])
                              && !(is_div && b_zero);
                  neg_rem_d = is_signed && A[WIDTH-1];
                  state_d   = ST_RUN;
               end
            end
         end

         ST_RUN: begin
            acc_d = step_acc;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = ST_FIX;
            end
         end

         ST_FIX: begin
            done = 1'b1;
            if (op_q == OP_MUL) begin
               {hi_d, lo_d} = neg_res_q ? -acc_q : acc_q;
            end else begin
               hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
               lo_d = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            end
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A flush abandons the operation without touching HI/LO
      if (cancel && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
         done    = 1'b0;
      end

      // Reset discards the result, so no completion is signalled either
      if (reset) begin
         done = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_MUL;
         acc_q     <= '0;
         opnd_q    <= '0;
         cnt_q     <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         cnt_q     <= cnt_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign Hi   = hi_q;
   assign Lo   = lo_q;

endmodule : muldiv_unit
`default_nettype wire
